retrieval_mem_arbiter: RTL and testbench
========================================

RETRIEVAL_MEM_ARBITER -- requirements
Module: retrieval_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of retrieval requesters sharing one vector-database read port.
REQ-002 SHALL have parameter BUS_WIDTH, default 512, memory data width in bits; beat size is BUS_WIDTH/8 bytes.
REQ-003 SHALL have parameter LEN_W, default 8, burst-length field width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, maximum cycles without mem_rd_valid before a burst aborts.
REQ-005 SHALL have ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  per-requester burst request.
- req_ready  out  NUM_REQ  per-requester accept.
- req_addr  in  NUM_REQ x 32  burst byte start address.
- req_len  in  NUM_REQ x LEN_W  beat count.
- rsp_valid  out  NUM_REQ  one-hot data strobe to the granted requester.
- rsp_data  out  BUS_WIDTH  shared response data.
- rsp_last  out  1  final response of the burst.
- rsp_err  out  1  burst aborted by timeout.
- grant_id  out  $clog2(NUM_REQ)  currently or last granted requester.
- busy  out  1  burst in progress.
- mem_rd_en  out  1  memory read enable.
- mem_rd_addr  out  32  memory read address.
- mem_rd_data  in  BUS_WIDTH  memory read data.
- mem_rd_valid  in  1  memory data beat valid.

Function
REQ-006 SHALL implement a two-state FSM: IDLE and BURST.
REQ-007 In IDLE, req_ready SHALL be combinational and one-hot: only the round-robin winner among asserted req_valid bits; all zero in BURST.
REQ-008 Round-robin search SHALL start at (last_grant+1) mod NUM_REQ; last_grant resets to NUM_REQ-1, so requester 0 has first priority.
REQ-009 On req_valid&req_ready, the block SHALL latch addr and len, set grant_id and last_grant to the winner, and enter BURST next cycle.
REQ-010 In the same edge, the block SHALL set mem_rd_en=1, mem_rd_addr=req_addr, busy=1, clear the beat and timeout counters.
REQ-011 req_len=0 SHALL be treated as 1 beat; otherwise beats=req_len.
REQ-012 In BURST, each mem_rd_valid SHALL advance mem_rd_addr by BUS_WIDTH/8, modulo 2^32 wrap, and increment the beat counter.
REQ-013 Response SHALL be registered with 1-cycle latency: rsp_data<=mem_rd_data, rsp_valid[grant_id]<=1 for one cycle per beat.
REQ-014 On the final beat, rsp_last SHALL assert with that beat's rsp_valid; mem_rd_en and busy deassert on the same edge; state returns to IDLE.
REQ-015 Back-to-back: a new grant SHALL be possible the cycle IDLE is re-entered; minimum 1 idle cycle between bursts.
REQ-016 Timeout counter SHALL increment each BURST cycle without mem_rd_valid and clear on mem_rd_valid.
REQ-017 When the timeout counter reaches TIMEOUT_CYCLES-1 with no mem_rd_valid: rsp_valid[grant_id], rsp_last and rsp_err pulse one cycle, rsp_data=0, mem_rd_en=0, busy=0, state IDLE.
REQ-018 mem_rd_valid in IDLE SHALL be ignored: no rsp_valid and no address change.
REQ-019 mem_rd_valid and timeout expiry in the same cycle SHALL count as a valid beat; no abort.
REQ-020 req_valid deassertion or change of req_addr/req_len during BURST SHALL have no effect on the active burst.

Reset
REQ-021 While rst_n=0 and asynchronously on assertion:
- state=IDLE, last_grant=NUM_REQ-1.
- mem_rd_en=0, mem_rd_addr=0.
- rsp_valid=0, rsp_data=0, rsp_last=0, rsp_err=0.
- grant_id=0, busy=0, counters=0.
REQ-022 Reset mid-burst SHALL abandon the burst without rsp_last or rsp_err.

Verification
REQ-023 Req1 addr 0x1000 len 3, mem_rd_valid every cycle -> req_ready[1] for 1 cycle; mem_rd_addr 0x1000/0x1040/0x1080; 3 rsp_valid[1] pulses; rsp_last on the 3rd; grant_id=1.
REQ-024 All four req_valid held after reset, len 1 each -> grant order 0,1,2,3,0; at most one req_ready bit set per cycle.
REQ-025 Req2 len 0 -> exactly one beat, rsp_last with the first rsp_valid[2].
REQ-026 TIMEOUT_CYCLES=16, req0 len 4, no mem_rd_valid -> 16 cycles later rsp_valid[0], rsp_last and rsp_err pulse together; mem_rd_en=0; req_ready usable next cycle.
REQ-027 rst_n low during beat 2 of a 4-beat burst to req3 -> all outputs at reset values; after release, simultaneous req0 and req3 grant req0 first.
REQ-028 mem_rd_valid pulses while IDLE; mem_rd_addr 0xFFFFFFC0 burst of 2 -> no rsp_valid while IDLE; address wraps to 0x00000000 on the second beat.

Source files
------------

// File: rtl/retrieval_mem_arbiter.sv
// Round-robin arbiter granting retrieval requesters burst access to one shared
// vector-database read port, with registered responses and a per-burst timeout.
module retrieval_mem_arbiter #(
  parameter  int NUM_REQ        = 4,
  parameter  int BUS_WIDTH      = 512,
  parameter  int LEN_W          = 8,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int IDW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0][31:0]         req_addr,
  input  logic [NUM_REQ-1:0][LEN_W-1:0]    req_len,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [BUS_WIDTH-1:0]             rsp_data,
  output logic                             rsp_last,
  output logic                             rsp_err,
  output logic [IDW-1:0]                   grant_id,
  output logic                             busy,
  output logic                             mem_rd_en,
  output logic [31:0]                      mem_rd_addr,
  input  logic [BUS_WIDTH-1:0]             mem_rd_data,
  input  logic                             mem_rd_valid
);

  localparam int          TO_W         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TIMEOUT_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] BEAT_BYTES   = 32'(BUS_WIDTH / 8);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                 state_q;
  logic [IDW-1:0]         lastGrant_q;
  logic [IDW-1:0]         grantId_q;
  logic                   busy_q;
  logic                   memRdEn_q;
  logic [31:0]            memRdAddr_q;
  logic [NUM_REQ-1:0]     rspValid_q;
  logic [BUS_WIDTH-1:0]   rspData_q;
  logic                   rspLast_q;
  logic                   rspErr_q;
  logic [LEN_W-1:0]       beats_q;
  logic [LEN_W-1:0]       beatCnt_q;
  logic [TO_W-1:0]        timeoutCnt_q;

  logic                   winnerFound;
  logic [IDW-1:0]         winnerId;
  logic [IDW-1:0]         cand;
  logic [LEN_W-1:0]       burstBeats_d;
  logic [31:0]            nextAddr_d;
  logic [NUM_REQ-1:0]     grantOneHot;
  logic                   lastBeat;

  // Search starts just after the previous winner so every requester gets a turn.
  always_comb begin
    winnerFound = 1'b0;
    winnerId    = lastGrant_q;
    cand        = '0;
    for (int offs = 1; offs <= NUM_REQ; offs++) begin
      cand = IDW'((int'(lastGrant_q) + offs) % NUM_REQ);
      if (!winnerFound && req_valid[cand]) begin
        winnerFound = 1'b1;
        winnerId    = cand;
      end
    end
  end

  assign req_ready    = (state_q == IDLE && winnerFound) ? (NUM_REQ'(1) << winnerId) : '0;
  assign burstBeats_d = (req_len[winnerId] == '0) ? LEN_W'(1) : req_len[winnerId];
  assign nextAddr_d   = memRdAddr_q + BEAT_BYTES;
  assign grantOneHot  = NUM_REQ'(1) << grantId_q;
  assign lastBeat     = (beatCnt_q == beats_q - LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lastGrant_q  <= IDW'(NUM_REQ - 1);
      grantId_q    <= '0;
      busy_q       <= 1'b0;
      memRdEn_q    <= 1'b0;
      memRdAddr_q  <= '0;
      rspValid_q   <= '0;
      rspData_q    <= '0;
      rspLast_q    <= 1'b0;
      rspErr_q     <= 1'b0;
      beats_q      <= '0;
      beatCnt_q    <= '0;
      timeoutCnt_q <= '0;
    end else begin
      rspValid_q <= '0;
      rspLast_q  <= 1'b0;
      rspErr_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (winnerFound) begin
            state_q      <= BURST;
            lastGrant_q  <= winnerId;
            grantId_q    <= winnerId;
            busy_q       <= 1'b1;
            memRdEn_q    <= 1'b1;
            memRdAddr_q  <= req_addr[winnerId];
            beats_q      <= burstBeats_d;
            beatCnt_q    <= '0;
            timeoutCnt_q <= '0;
          end
        end
        BURST: begin
          // A beat arriving on the expiry cycle still wins over the abort.
          if (mem_rd_valid) begin
            memRdAddr_q  <= nextAddr_d;
            beatCnt_q    <= beatCnt_q + LEN_W'(1);
            timeoutCnt_q <= '0;
            rspValid_q   <= grantOneHot;
            rspData_q    <= mem_rd_data;
            if (lastBeat) begin
              rspLast_q <= 1'b1;
              memRdEn_q <= 1'b0;
              busy_q    <= 1'b0;
              state_q   <= IDLE;
            end
          end else if (timeoutCnt_q == TIMEOUT_LAST) begin
            rspValid_q <= grantOneHot;
            rspData_q  <= '0;
            rspLast_q  <= 1'b1;
            rspErr_q   <= 1'b1;
            memRdEn_q  <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else begin
            timeoutCnt_q <= timeoutCnt_q + TO_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid   = rspValid_q;
  assign rsp_data    = rspData_q;
  assign rsp_last    = rspLast_q;
  assign rsp_err     = rspErr_q;
  assign grant_id    = grantId_q;
  assign busy        = busy_q;
  assign mem_rd_en   = memRdEn_q;
  assign mem_rd_addr = memRdAddr_q;

endmodule

// File: tb/tb_retrieval_mem_arbiter.sv
// Directed bench for retrieval_mem_arbiter: single bursts, round-robin order,
// zero-length bursts, timeout abort, mid-burst reset and address wrap.
module tb_retrieval_mem_arbiter;

  localparam int NumReq        = 4;
  localparam int BusWidth      = 512;
  localparam int LenW          = 8;
  localparam int TimeoutCycles = 16;

  logic                           clk = 1'b0;
  logic                           rst_n;
  logic [NumReq-1:0]              reqValid;
  logic [NumReq-1:0]              reqReady;
  logic [NumReq-1:0][31:0]        reqAddr;
  logic [NumReq-1:0][LenW-1:0]    reqLen;
  logic [NumReq-1:0]              rspValid;
  logic [BusWidth-1:0]            rspData;
  logic                           rspLast;
  logic                           rspErr;
  logic [1:0]                     grantId;
  logic                           busy;
  logic                           memRdEn;
  logic [31:0]                    memRdAddr;
  logic [BusWidth-1:0]            memRdData;
  logic                           memRdValid;

  int checks = 0;
  int errors = 0;

  retrieval_mem_arbiter #(
    .NUM_REQ(NumReq),
    .BUS_WIDTH(BusWidth),
    .LEN_W(LenW),
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(reqValid),
    .req_ready(reqReady),
    .req_addr(reqAddr),
    .req_len(reqLen),
    .rsp_valid(rspValid),
    .rsp_data(rspData),
    .rsp_last(rspLast),
    .rsp_err(rspErr),
    .grant_id(grantId),
    .busy(busy),
    .mem_rd_en(memRdEn),
    .mem_rd_addr(memRdAddr),
    .mem_rd_data(memRdData),
    .mem_rd_valid(memRdValid)
  );

  always #5 clk = ~clk;

  function automatic logic [BusWidth-1:0] mkData(input int k);
    logic [31:0] word;
    word = 32'hA500_0000 + 32'(k);
    return {16{word}};
  endfunction

  task automatic checkOutput(input string tag, input logic [BusWidth-1:0] observed,
                             input logic [BusWidth-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NumReq-1:0] valid, input logic beat, input int k);
    reqValid   = valid;
    memRdValid = beat;
    memRdData  = mkData(k);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rd_en"}, memRdEn, 0);
    checkOutput({tag, "_rd_addr"}, memRdAddr, 0);
    checkOutput({tag, "_rsp_valid"}, rspValid, 0);
    checkOutput({tag, "_rsp_data"}, rspData, 0);
    checkOutput({tag, "_rsp_last"}, rspLast, 0);
    checkOutput({tag, "_rsp_err"}, rspErr, 0);
    checkOutput({tag, "_grant"}, grantId, 0);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    reqAddr    = '0;
    reqLen     = '0;
    applyStimulus(4'b0000, 1'b0, 0);
    memRdData  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkResetState("reset");
    rst_n = 1'b1;

    // Requester 1: three beats from 0x1000, inputs scrambled after the grant.
    reqAddr[1] = 32'h0000_1000;
    reqLen[1]  = 8'd3;
    applyStimulus(4'b0010, 1'b0, 0);
    #1;
    checkOutput("a_ready", reqReady, 4'b0010);
    tick();
    reqAddr[1] = 32'hDEAD_0000;
    reqLen[1]  = 8'd1;
    applyStimulus(4'b0000, 1'b1, 1);
    checkOutput("a_busy", busy, 1);
    checkOutput("a_rd_en", memRdEn, 1);
    checkOutput("a_grant", grantId, 1);
    checkOutput("a_addr0", memRdAddr, 32'h0000_1000);
    checkOutput("a_ready_burst", reqReady, 0);
    tick();
    checkOutput("a_rsp_valid1", rspValid, 4'b0010);
    checkOutput("a_rsp_data1", rspData, mkData(1));
    checkOutput("a_rsp_last1", rspLast, 0);
    checkOutput("a_addr1", memRdAddr, 32'h0000_1040);
    applyStimulus(4'b0000, 1'b1, 2);
    tick();
    checkOutput("a_rsp_data2", rspData, mkData(2));
    checkOutput("a_rsp_last2", rspLast, 0);
    checkOutput("a_addr2", memRdAddr, 32'h0000_1080);
    applyStimulus(4'b0000, 1'b1, 3);
    tick();
    checkOutput("a_rsp_valid3", rspValid, 4'b0010);
    checkOutput("a_rsp_last3", rspLast, 1);
    checkOutput("a_rsp_data3", rspData, mkData(3));
    checkOutput("a_busy_end", busy, 0);
    checkOutput("a_rd_en_end", memRdEn, 0);
    checkOutput("a_err", rspErr, 0);
    applyStimulus(4'b0000, 1'b0, 0);
    tick();
    checkOutput("a_rsp_valid_idle", rspValid, 0);
    checkOutput("a_rsp_last_idle", rspLast, 0);

    // Fresh reset, then all four requesters held: grants rotate 0,1,2,3,0.
    rst_n = 1'b0;
    #2;
    checkOutput("b_reset_grant", grantId, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NumReq; i++) begin
      reqAddr[i] = 32'h0001_0000 + 32'(i * 32'h100);
      reqLen[i]  = 8'd1;
    end
    applyStimulus(4'b1111, 1'b0, 0);
    for (int k = 0; k < 5; k++) begin
      int expId;
      expId = k % NumReq;
      #1;
      checkOutput("b_ready", reqReady, NumReq'(1) << expId);
      tick();
      checkOutput("b_grant", grantId, expId);
      checkOutput("b_ready_burst", reqReady, 0);
      checkOutput("b_addr", memRdAddr, 32'h0001_0000 + 32'(expId * 32'h100));
      applyStimulus(4'b1111, 1'b1, 10 + k);
      tick();
      checkOutput("b_rsp_valid", rspValid, NumReq'(1) << expId);
      checkOutput("b_rsp_last", rspLast, 1);
      applyStimulus(4'b1111, 1'b0, 0);
    end
    applyStimulus(4'b0000, 1'b0, 0);

    // Zero length on requester 2 is a single beat.
    reqAddr[2] = 32'h0000_2000;
    reqLen[2]  = 8'd0;
    applyStimulus(4'b0100, 1'b0, 0);
    #1;
    checkOutput("c_ready", reqReady, 4'b0100);
    tick();
    applyStimulus(4'b0000, 1'b1, 4);
    checkOutput("c_grant", grantId, 2);
    checkOutput("c_addr", memRdAddr, 32'h0000_2000);
    tick();
    checkOutput("c_rsp_valid", rspValid, 4'b0100);
    checkOutput("c_rsp_last", rspLast, 1);
    checkOutput("c_busy", busy, 0);
    checkOutput("c_rsp_data", rspData, mkData(4));
    applyStimulus(4'b0000, 1'b0, 0);

    // Requester 0 never sees data: abort sixteen cycles after the grant.
    reqAddr[0] = 32'h0000_4000;
    reqLen[0]  = 8'd4;
    applyStimulus(4'b0001, 1'b0, 0);
    #1;
    checkOutput("d_ready", reqReady, 4'b0001);
    tick();
    applyStimulus(4'b0000, 1'b0, 0);
    checkOutput("d_grant", grantId, 0);
    repeat (TimeoutCycles - 1) tick();
    checkOutput("d_busy_wait", busy, 1);
    checkOutput("d_rsp_valid_wait", rspValid, 0);
    checkOutput("d_err_wait", rspErr, 0);
    tick();
    checkOutput("d_rsp_valid_to", rspValid, 4'b0001);
    checkOutput("d_rsp_last_to", rspLast, 1);
    checkOutput("d_rsp_err_to", rspErr, 1);
    checkOutput("d_rsp_data_to", rspData, 0);
    checkOutput("d_rd_en_to", memRdEn, 0);
    checkOutput("d_busy_to", busy, 0);
    reqLen[0] = 8'd1;
    applyStimulus(4'b0001, 1'b0, 0);
    #1;
    checkOutput("d_ready_after", reqReady, 4'b0001);
    tick();
    checkOutput("d_err_clear", rspErr, 0);
    checkOutput("d_busy_regrant", busy, 1);
    checkOutput("d_addr_regrant", memRdAddr, 32'h0000_4000);
    applyStimulus(4'b0000, 1'b1, 5);
    tick();
    checkOutput("d_rsp_last_regrant", rspLast, 1);
    checkOutput("d_rsp_err_regrant", rspErr, 0);
    applyStimulus(4'b0000, 1'b0, 0);

    // A beat on the expiry cycle counts as data, not an abort.
    reqAddr[1] = 32'h0000_5000;
    reqLen[1]  = 8'd2;
    applyStimulus(4'b0010, 1'b0, 0);
    tick();
    applyStimulus(4'b0000, 1'b0, 0);
    repeat (TimeoutCycles - 1) tick();
    applyStimulus(4'b0000, 1'b1, 6);
    tick();
    checkOutput("e_rsp_valid", rspValid, 4'b0010);
    checkOutput("e_rsp_err", rspErr, 0);
    checkOutput("e_rsp_last", rspLast, 0);
    checkOutput("e_busy", busy, 1);
    checkOutput("e_addr", memRdAddr, 32'h0000_5040);
    applyStimulus(4'b0000, 1'b1, 7);
    tick();
    checkOutput("e_rsp_last2", rspLast, 1);
    checkOutput("e_rsp_err2", rspErr, 0);
    applyStimulus(4'b0000, 1'b0, 0);

    // Reset during beat 2 of a four-beat burst to requester 3.
    reqAddr[3] = 32'h0000_3000;
    reqLen[3]  = 8'd4;
    applyStimulus(4'b1000, 1'b0, 0);
    #1;
    checkOutput("f_ready", reqReady, 4'b1000);
    tick();
    applyStimulus(4'b0000, 1'b1, 8);
    checkOutput("f_grant", grantId, 3);
    tick();
    checkOutput("f_beat1", rspValid, 4'b1000);
    applyStimulus(4'b0000, 1'b1, 9);
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState("f_async");
    applyStimulus(4'b0000, 1'b0, 0);
    tick();
    rst_n = 1'b1;
    reqAddr[0] = 32'h0000_0100;
    reqLen[0]  = 8'd1;
    applyStimulus(4'b1001, 1'b0, 0);
    #1;
    checkOutput("f_ready_after", reqReady, 4'b0001);
    tick();
    checkOutput("f_grant_after", grantId, 0);
    checkOutput("f_addr_after", memRdAddr, 32'h0000_0100);
    applyStimulus(4'b0000, 1'b1, 10);
    tick();
    checkOutput("f_rsp_valid_after", rspValid, 4'b0001);
    checkOutput("f_rsp_last_after", rspLast, 1);
    applyStimulus(4'b0000, 1'b0, 0);

    // Stray beats while idle are ignored.
    applyStimulus(4'b0000, 1'b1, 11);
    tick();
    checkOutput("g_idle_rsp_valid", rspValid, 0);
    checkOutput("g_idle_addr", memRdAddr, 32'h0000_0140);
    checkOutput("g_idle_data", rspData, mkData(10));
    applyStimulus(4'b0000, 1'b0, 0);
    tick();
    applyStimulus(4'b0000, 1'b1, 11);
    tick();
    checkOutput("g_idle_rsp_valid2", rspValid, 0);
    checkOutput("g_idle_addr2", memRdAddr, 32'h0000_0140);
    applyStimulus(4'b0000, 1'b0, 0);

    // Burst starting one beat below the top of the address space wraps.
    reqAddr[1] = 32'hFFFF_FFC0;
    reqLen[1]  = 8'd2;
    applyStimulus(4'b0010, 1'b0, 0);
    #1;
    checkOutput("g_ready", reqReady, 4'b0010);
    tick();
    applyStimulus(4'b0000, 1'b1, 12);
    checkOutput("g_addr0", memRdAddr, 32'hFFFF_FFC0);
    tick();
    checkOutput("g_addr_wrap", memRdAddr, 32'h0000_0000);
    checkOutput("g_rsp_valid1", rspValid, 4'b0010);
    applyStimulus(4'b0000, 1'b1, 13);
    tick();
    checkOutput("g_rsp_last", rspLast, 1);
    checkOutput("g_addr_end", memRdAddr, 32'h0000_0040);
    applyStimulus(4'b0000, 1'b0, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
